// File: rtl/key_conditioner.sv
// key_conditioner: input stage for the raw active-low pushbuttons.
// For every key it provides a 2-flop synchroniser, a debounce FSM and
// registered one-cycle press/release pulses.
// key_out is the clean active-low level; key_any is the OR of key_press,
// registered in the same cycle as it.
// Optional build macro: KEY_REPEAT_EN adds auto-repeat key_press pulses
// while a key is held down. Without it, REPEAT_DELAY and REPEAT_PERIOD are unused.
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                key_any
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD);
    localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
`endif

    typedef enum logic [1:0] {
        UP      = 2'd0,
        PEND_DN = 2'd1,
        DOWN    = 2'd2,
        PEND_UP = 2'd3
    } key_state_t;

    logic [NUM_KEYS-1:0] sync_s1;
    logic [NUM_KEYS-1:0] sync_s2;
    logic [NUM_KEYS-1:0] press_d;
    logic [NUM_KEYS-1:0] release_d;

    // Two-flop synchroniser; idles at 1 because the buttons are active-low.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_s1 <= '1;
            sync_s2 <= '1;
        end else begin
            sync_s1 <= key_raw;
            sync_s2 <= sync_s1;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_state_t       state_q;
        key_state_t       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             out_q;
        logic             out_d;
        logic             press_acc;
        logic             release_acc;
        logic             rep_fire;

        // Debounce state, counter and clean level for this key.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                state_q <= UP;
                cnt_q   <= '0;
                out_q   <= 1'b1;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
            end
        end

        // Debounce FSM: a change is accepted once the synchronised level
        // has differed for DEBOUNCE_CYCLES+1 consecutive samples.
        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            out_d       = out_q;
            press_acc   = 1'b0;
            release_acc = 1'b0;
            case (state_q)
                UP: begin
                    if (!sync_s2[k]) begin
                        state_d = PEND_DN;
                        cnt_d   = CNT_ONE;
                    end
                end
                PEND_DN: begin
                    if (sync_s2[k]) begin
                        state_d = UP;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = DOWN;
                        cnt_d     = '0;
                        out_d     = 1'b0;
                        press_acc = 1'b1;
                    end else if (cnt_q < CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DOWN: begin
                    if (sync_s2[k]) begin
                        state_d = PEND_UP;
                        cnt_d   = CNT_ONE;
                    end
                end
                PEND_UP: begin
                    if (!sync_s2[k]) begin
                        state_d = DOWN;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d     = UP;
                        cnt_d       = '0;
                        out_d       = 1'b1;
                        release_acc = 1'b1;
                    end else if (cnt_q < CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = UP;
                    cnt_d   = '0;
                    out_d   = 1'b1;
                end
            endcase
        end

`ifdef KEY_REPEAT_EN
        logic [REP_W-1:0] rep_q;
        logic [REP_W-1:0] rep_d;
        logic [REP_W-1:0] rep_inc;
        logic             rep_first_q;
        logic             rep_first_d;

        // Repeat counter plus a flag telling whether the first (long) delay
        // or the shorter period is being timed.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                rep_q       <= '0;
                rep_first_q <= 1'b1;
            end else begin
                rep_q       <= rep_d;
                rep_first_q <= rep_first_d;
            end
        end

        // Count only while the key stays down; leaving for PEND_UP freezes
        // the count, so a release glitch does not restart the repeat timing.
        always_comb begin
            rep_d       = rep_q;
            rep_first_d = rep_first_q;
            rep_inc     = rep_q + REP_ONE;
            rep_fire    = 1'b0;
            if (press_acc || release_acc) begin
                rep_d       = '0;
                rep_first_d = 1'b1;
            end else if (state_q == DOWN && state_d == DOWN) begin
                if (rep_inc == (rep_first_q ? REP_FIRST : REP_NEXT)) begin
                    rep_fire    = 1'b1;
                    rep_d       = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_d = rep_inc;
                end
            end
        end
`else
        assign rep_fire = 1'b0;
`endif

        assign key_out[k]   = out_q;
        assign press_d[k]   = press_acc | rep_fire;
        assign release_d[k] = release_acc;
    end

    // Pulses are registered so they line up with the key_out change.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_press   <= '0;
            key_release <= '0;
            key_any     <= 1'b0;
        end else begin
            key_press   <= press_d;
            key_release <= release_d;
            key_any     <= |press_d;
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Table-driven vectors for the basic press/release/glitch cases, followed by
// hand-written sequences for reset in the middle of a debounce and for the
// held-key (repeat) behaviour. Build with KEY_REPEAT_EN defined to exercise repeats.
module tb_key_conditioner;

    logic       clock;
    logic       resetn;
    logic [3:0] key_raw;
    logic [3:0] key_out;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic       key_any;

    int checks = 0;
    int errors = 0;

`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [3:0] raw;
        logic [3:0] exp_out;
        logic [3:0] exp_press;
        logic [3:0] exp_rel;
        logic       exp_any;
    } vec_t;

    vec_t vecs[$];

    key_conditioner #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .key_raw     (key_raw),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release),
        .key_any     (key_any)
    );

    // 100 MHz free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic void add_vec(input string tag, input logic [3:0] raw,
                                    input logic [3:0] e_out, input logic [3:0] e_press,
                                    input logic [3:0] e_rel, input logic e_any, input int n);
        vec_t v;
        v.tag       = tag;
        v.raw       = raw;
        v.exp_out   = e_out;
        v.exp_press = e_press;
        v.exp_rel   = e_rel;
        v.exp_any   = e_any;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    // Drive key_raw, let one rising edge pass, and return 1 time unit after it.
    task automatic apply_stimulus(input logic [3:0] raw);
        key_raw = raw;
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [3:0] e_out,
                                input logic [3:0] e_press, input logic [3:0] e_rel,
                                input logic e_any);
        checks++;
        if (key_out !== e_out) begin
            errors++;
            $display("[TB] FAIL %s key_out: got %b, expected %b (t=%0t)", tag, key_out, e_out, $time);
        end
        checks++;
        if (key_press !== e_press) begin
            errors++;
            $display("[TB] FAIL %s key_press: got %b, expected %b (t=%0t)", tag, key_press, e_press, $time);
        end
        checks++;
        if (key_release !== e_rel) begin
            errors++;
            $display("[TB] FAIL %s key_release: got %b, expected %b (t=%0t)", tag, key_release, e_rel, $time);
        end
        checks++;
        if (key_any !== e_any) begin
            errors++;
            $display("[TB] FAIL %s key_any: got %b, expected %b (t=%0t)", tag, key_any, e_any, $time);
        end
    endtask

    initial begin
        // Entry n's first edge is E1 for a new raw level, so outputs change at entry n+6.
        add_vec("press0_wait",   4'b1110, 4'b1111, 4'b0000, 4'b0000, 1'b0, 6);
        add_vec("press0_accept", 4'b1110, 4'b1110, 4'b0001, 4'b0000, 1'b1, 1);
        add_vec("press0_hold",   4'b1110, 4'b1110, 4'b0000, 4'b0000, 1'b0, 2);
        add_vec("rel0_wait",     4'b1111, 4'b1110, 4'b0000, 4'b0000, 1'b0, 6);
        add_vec("rel0_accept",   4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1);
        add_vec("rel0_idle",     4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2);
        add_vec("glitch2_low",   4'b1011, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4);
        add_vec("glitch2_after", 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 8);
        add_vec("dual_wait",     4'b0101, 4'b1111, 4'b0000, 4'b0000, 1'b0, 6);
        add_vec("dual_accept",   4'b0101, 4'b0101, 4'b1010, 4'b0000, 1'b1, 1);
        add_vec("dual_hold",     4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2);
        add_vec("dual_rel_wait", 4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b0, 6);
        add_vec("dual_rel",      4'b1111, 4'b1111, 4'b0000, 4'b1010, 1'b0, 1);
        add_vec("dual_idle",     4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2);

        resetn  = 1'b0;
        key_raw = 4'b1111;
        #23;
        check_output("reset_state", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].raw);
            check_output(vecs[i].tag, vecs[i].exp_out, vecs[i].exp_press,
                         vecs[i].exp_rel, vecs[i].exp_any);
        end

        // Key 1 down, then key 0 starts debouncing; reset hits with key 0 at cnt=2.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(4'b1101);
            check_output("k1_wait", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        end
        apply_stimulus(4'b1101);
        check_output("k1_accept", 4'b1101, 4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(4'b1100);
            check_output("k0_pend", 4'b1101, 4'b0000, 4'b0000, 1'b0);
        end
        #2;
        resetn = 1'b0;
        #1;
        check_output("async_reset", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        @(posedge clock);
        #1;
        check_output("reset_held", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(4'b1100);
            check_output("restart_wait", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        end
        apply_stimulus(4'b1100);
        check_output("restart_accept", 4'b1100, 4'b0011, 4'b0000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(4'b1111);
            check_output("restart_rel_wait", 4'b1100, 4'b0000, 4'b0000, 1'b0);
        end
        apply_stimulus(4'b1111);
        check_output("restart_rel", 4'b1111, 4'b0000, 4'b0011, 1'b0);
        apply_stimulus(4'b1111);
        check_output("restart_idle", 4'b1111, 4'b0000, 4'b0000, 1'b0);

        // Long hold on key 0: accept edge A is entry 6 (j=0); raw goes high at j=36,
        // so PEND_UP is entered at j=38 and the release is accepted at j=42.
        for (int i = 0; i < 52; i++) begin
            int         j;
            logic [3:0] raw;
            logic [3:0] e_out;
            logic [3:0] e_rel;
            logic       p;
            j     = i - 6;
            raw   = (j < 36) ? 4'b1110 : 4'b1111;
            e_out = (j >= 0 && j < 42) ? 4'b1110 : 4'b1111;
            e_rel = (j == 42) ? 4'b0001 : 4'b0000;
            p     = (j == 0) ||
                    (REP_EN && j >= 10 && j <= 37 && ((j - 10) % 3 == 0));
            apply_stimulus(raw);
            check_output($sformatf("hold_j%0d", j), e_out, {3'b000, p}, e_rel, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
